// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx : start/LSB-first data/[even parity]/stop serial receiver, mid-bit sampling
// Optional even-parity check enabled by defining PARITY_RX_EN.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
`ifdef PARITY_RX_EN
  output logic                 parity_err,
`endif
  output logic                 frame_err
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

`ifdef PARITY_RX_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                 state, state_n;
  logic                   rx_meta, rx_s, rx_prev;
  logic [CW-1:0]          cnt, cnt_n;
  logic [IW-1:0]          idx, idx_n;
  logic [DATA_BITS-1:0]   shreg, shreg_n, data_n;
  logic                   valid_n, ferr_n;
  logic                   par_mismatch;
`ifdef PARITY_RX_EN
  logic                   par_bit, par_n, perr_n;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev   <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef PARITY_RX_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_meta   <= rx;
      rx_s      <= rx_meta;
      rx_prev   <= rx_s;
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shreg     <= shreg_n;
      data      <= data_n;
      valid     <= valid_n;
      frame_err <= ferr_n;
`ifdef PARITY_RX_EN
      par_bit    <= par_n;
      parity_err <= perr_n;
`endif
    end
  end

  // Even parity: data bits XOR parity bit must be zero.
`ifdef PARITY_RX_EN
  assign par_mismatch = ^{shreg, par_bit};
`else
  assign par_mismatch = 1'b0;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    data_n  = data;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
`ifdef PARITY_RX_EN
    par_n   = par_bit;
    perr_n  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (rx_prev && !rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
          if (idx == IDX_LAST) begin
`ifdef PARITY_RX_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            idx_n = idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`ifdef PARITY_RX_EN
      PARITY: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          par_n   = rx_s;
          state_n = STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        // Returning to IDLE at mid-stop lets a zero-gap next start bit be caught.
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
          ferr_n  = !rx_s;
`ifdef PARITY_RX_EN
          perr_n  = par_mismatch;
`endif
          if (rx_s && !par_mismatch) begin
            data_n  = shreg;
            valid_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx : frame-level scoreboard bench for uart_rx (directed + random frames)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx;
  localparam int CPB  = 16;
  localparam int DB   = 8;
  localparam int HALF = CPB / 2;
`ifdef PARITY_RX_EN
  localparam int NB = DB + 1;
`else
  localparam int NB = DB;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx  = 1'b1;
  logic [DB-1:0] data;
  logic          valid, frame_err, parity_err;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
`ifdef PARITY_RX_EN
    .parity_err(parity_err),
`endif
    .frame_err (frame_err)
  );
`ifndef PARITY_RX_EN
  assign parity_err = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic          fe;
    logic          pe;
    logic [DB-1:0] d;
    int            lo;
    int            hi;
  } ev_t;

  ev_t           q[$];
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  logic [DB-1:0] model_data = '0;
  int            n_valid = 0, n_ferr = 0, n_perr = 0;
  int            last_v_cyc = 0, prev_v_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: each frame queued with its expected outcome and arrival window.
  always @(negedge clk) begin
    if (rst) begin
      chk("reset_valid", valid, 0);
      chk("reset_frame_err", frame_err, 0);
      chk("reset_parity_err", parity_err, 0);
      chk("reset_data", data, 0);
      model_data = '0;
    end else begin
      if (valid || frame_err || parity_err) begin
        if (valid) begin n_valid++; prev_v_cyc = last_v_cyc; last_v_cyc = cyc; end
        if (frame_err) n_ferr++;
        if (parity_err) n_perr++;
        if (q.size() == 0 || cyc < q[0].lo) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got valid=%b ferr=%b perr=%b expected none at cycle %0d",
                   valid, frame_err, parity_err, cyc);
        end else begin
          chk("pulse_valid", valid, q[0].v);
          chk("pulse_frame_err", frame_err, q[0].fe);
          chk("pulse_parity_err", parity_err, q[0].pe);
          if (q[0].v) model_data = q[0].d;
          void'(q.pop_front());
        end
      end else if (q.size() > 0 && cyc > q[0].hi) begin
        checks++;
        errors++;
        $display("FAIL missed_pulse: got none expected v=%b fe=%b pe=%b by cycle %0d (now %0d)",
                 q[0].v, q[0].fe, q[0].pe, q[0].hi, cyc);
        void'(q.pop_front());
      end
      chk("data_hold", data, model_data);
    end
  end

  // All tasks are entered and left one time unit after a rising edge.
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic glitch(input int len);
    rx = 1'b0;
    repeat (len) @(posedge clk);
    #1;
    idle(CPB);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic par_ok,
                            input int abort_bit);
    logic [NB+1:0] bits;
    ev_t           ev;
    int            nom;
    bits       = '0;
    bits[DB:1] = d;
`ifdef PARITY_RX_EN
    bits[DB+1] = (^d) ^ !par_ok;
`endif
    bits[NB+1] = stop;
    nom   = cyc + 3 + HALF + (NB + 1) * CPB + 1;
    ev.d  = d;
    ev.fe = !stop;
`ifdef PARITY_RX_EN
    ev.pe = !par_ok;
    ev.v  = stop && par_ok;
`else
    ev.pe = 1'b0;
    ev.v  = stop;
`endif
    ev.lo = nom - 1;
    ev.hi = nom + 1;
    if (abort_bit < 0) q.push_back(ev);
    for (int i = 0; i < NB + 2; i++) begin
      rx = bits[i];
      if (abort_bit >= 0 && i == abort_bit + 1) begin
        repeat (HALF) @(posedge clk);
        #1;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        return;
      end
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DB-1:0] d;
    logic          stop, pok;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(5);

    send_frame(8'hA5, 1'b1, 1'b1, -1);
    idle(4);
    chk("tp_a5_data", data, 8'hA5);
    chk("tp_a5_nvalid", n_valid, 1);
    chk("tp_a5_nferr", n_ferr, 0);

    glitch(4);
    send_frame(8'h3C, 1'b1, 1'b1, -1);
    idle(4);
    chk("tp_3c_data", data, 8'h3C);
    chk("tp_3c_nvalid", n_valid, 2);

    send_frame(8'h5A, 1'b0, 1'b1, -1);
    rx = 1'b0;
    repeat (40 * CPB) @(posedge clk);
    #1;
    idle(CPB);
    chk("tp_brk_data", data, 8'h3C);
    chk("tp_brk_nferr", n_ferr, 1);
    chk("tp_brk_nvalid", n_valid, 2);

    send_frame(8'h00, 1'b1, 1'b1, -1);
    send_frame(8'hFF, 1'b1, 1'b1, -1);
    idle(4);
    chk("tp_b2b_data", data, 8'hFF);
    chk("tp_b2b_nvalid", n_valid, 4);
    chk("tp_b2b_spacing", last_v_cyc - prev_v_cyc, (NB + 2) * CPB);

    send_frame(8'h81, 1'b1, 1'b1, 3);
    idle(CPB);
    chk("tp_abort_data", data, 8'h00);
    chk("tp_abort_nvalid", n_valid, 4);
    send_frame(8'h7E, 1'b1, 1'b1, -1);
    idle(4);
    chk("tp_7e_data", data, 8'h7E);
    chk("tp_7e_nvalid", n_valid, 5);

`ifdef PARITY_RX_EN
    send_frame(8'h01, 1'b1, 1'b0, -1);
    idle(4);
    chk("tp_par_bad_nperr", n_perr, 1);
    chk("tp_par_bad_data", data, 8'h7E);
    send_frame(8'h01, 1'b1, 1'b1, -1);
    idle(4);
    chk("tp_par_ok_data", data, 8'h01);
    chk("tp_par_ok_nvalid", n_valid, 6);
`endif

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) glitch($urandom_range(1, HALF - 3));
      d    = DB'($urandom);
      stop = ($urandom_range(0, 7) != 0);
`ifdef PARITY_RX_EN
      pok  = ($urandom_range(0, 4) != 0);
`else
      pok  = 1'b1;
`endif
      send_frame(d, stop, pok, -1);
      if (!stop) idle(CPB + $urandom_range(0, CPB));
      else idle($urandom_range(0, CPB));
    end

    for (int w = 0; w < 400 && q.size() > 0; w++) @(posedge clk);
    #1;
    idle(4);
    chk("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
